// File: rtl/rf_pkg.sv
// Shared types for the register-file write-back path.
package rf_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   typedef enum logic {SRC_ALU, SRC_LOAD} wb_src_t;
endpackage

// File: rtl/rf_writeback_ctrl_fifo.sv
// Load-result queue: synchronous FIFO of write-back requests.
module wb_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push_i,
   input  logic    pop_i,
   input  wb_req_t wr_data_i,
   output wb_req_t rd_data_o,
   output logic    full_o,
   output logic    empty_o
);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int AW = PW - 1;

   wb_req_t        mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q;
   logic [PW-1:0]  rd_ptr_q;
   logic [PW-1:0]  ptr_one;

   assign ptr_one   = {{(PW-1){1'b0}}, 1'b1};
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign full_o    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + ptr_one;
         if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + ptr_one;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end
endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port controller: ALU/load arbitration, registered write
// stage, pending-load scoreboard and write-to-read forwarding.
module rf_writeback_ctrl #(
   parameter int LQ_DEPTH = 4,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic            issue_is_load,
   input  logic [4:0]      issue_rd,
   output logic            issue_ready,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_data,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic            busy1,
   output logic            busy2,
   output logic            fwd_valid1,
   output logic            fwd_valid2,
   output logic [XLEN-1:0] fwd_data1,
   output logic [XLEN-1:0] fwd_data2,
   output logic            rfwrite,
   output logic [4:0]      waddr,
   output logic [XLEN-1:0] wdata
);
   import rf_pkg::*;

   wb_req_t         q_head;
   wb_req_t         ld_req;
   wb_req_t         sel_req;
   logic            q_full;
   logic            q_empty;
   logic            q_push;
   logic            q_pop;
   logic            ld_acc;
   logic            sel_valid;
   wb_src_t         sel_src;
   logic [31:0]     pending_q;
   logic [31:0]     pending_d;
   logic            rfwrite_q;
   logic [4:0]      waddr_q;
   logic [XLEN-1:0] wdata_q;

   assign ld_req.rd   = ld_rd;
   assign ld_req.data = ld_data;
   assign ld_ready    = !q_full;
   assign ld_acc      = ld_valid && ld_ready;

   wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (q_push),
      .pop_i     (q_pop),
      .wr_data_i (ld_req),
      .rd_data_o (q_head),
      .full_o    (q_full),
      .empty_o   (q_empty)
   );

   // ALU first, then the queue head; a load bypasses only an empty queue.
   always_comb begin
      sel_valid = 1'b0;
      sel_src   = SRC_ALU;
      sel_req   = '0;
      q_push    = 1'b0;
      q_pop     = 1'b0;
      if (alu_valid) begin
         sel_valid    = 1'b1;
         sel_req.rd   = alu_rd;
         sel_req.data = alu_data;
         q_push       = ld_acc;
      end else if (!q_empty) begin
         sel_valid = 1'b1;
         sel_src   = SRC_LOAD;
         sel_req   = q_head;
         q_pop     = 1'b1;
         q_push    = ld_acc;
      end else if (ld_acc) begin
         sel_valid = 1'b1;
         sel_src   = SRC_LOAD;
         sel_req   = ld_req;
      end
   end

   assign issue_ready = !(issue_is_load && pending_q[issue_rd]);

   always_comb begin
      pending_d = pending_q;
      if (sel_valid && sel_src == SRC_LOAD) pending_d[sel_req.rd] = 1'b0;
      if (issue_valid && issue_is_load && issue_ready && issue_rd != 5'd0)
         pending_d[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         rfwrite_q <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         pending_q <= pending_d;
         rfwrite_q <= sel_valid && (sel_req.rd != 5'd0);
         if (sel_valid) begin
            waddr_q <= sel_req.rd;
            wdata_q <= sel_req.data;
         end
      end
   end

   assign rfwrite    = rfwrite_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;

   assign busy1      = (raddr1 != 5'd0) && pending_q[raddr1];
   assign busy2      = (raddr2 != 5'd0) && pending_q[raddr2];
   assign fwd_valid1 = rfwrite_q && (waddr_q == raddr1) && (raddr1 != 5'd0);
   assign fwd_valid2 = rfwrite_q && (waddr_q == raddr2) && (raddr2 != 5'd0);
   assign fwd_data1  = wdata_q;
   assign fwd_data2  = wdata_q;
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Randomized and directed bench for rf_writeback_ctrl against a queue-based model.
module tb_rf_writeback_ctrl;
   localparam int LQ_DEPTH = 4;
   localparam int XLEN     = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            issue_valid = 1'b0, issue_is_load = 1'b0;
   logic [4:0]      issue_rd = '0;
   logic            issue_ready;
   logic            alu_valid = 1'b0;
   logic [4:0]      alu_rd = '0;
   logic [XLEN-1:0] alu_data = '0;
   logic            ld_valid = 1'b0;
   logic            ld_ready;
   logic [4:0]      ld_rd = '0;
   logic [XLEN-1:0] ld_data = '0;
   logic [4:0]      raddr1 = '0, raddr2 = '0;
   logic            busy1, busy2, fwd_valid1, fwd_valid2;
   logic [XLEN-1:0] fwd_data1, fwd_data2;
   logic            rfwrite;
   logic [4:0]      waddr;
   logic [XLEN-1:0] wdata;

   rf_writeback_ctrl #(.LQ_DEPTH(LQ_DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
      .issue_ready(issue_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .raddr1(raddr1), .raddr2(raddr2),
      .busy1(busy1), .busy2(busy2),
      .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .rfwrite(rfwrite), .waddr(waddr), .wdata(wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pend;
   logic        m_wr;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   int          n_checks = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle, entered and left on a falling edge.
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iv, input logic il, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
      logic rdy, acc, iss_rdy, sel, sload, f1, f2;
      logic [4:0] srd;
      logic [31:0] sdat;
      ent_t e;
      alu_valid = av; alu_rd = ard; alu_data = adat;
      ld_valid = lv; ld_rd = lrd; ld_data = ldat;
      issue_valid = iv; issue_is_load = il; issue_rd = ird;
      raddr1 = r1; raddr2 = r2;
      #1;
      rdy     = (mq.size() < LQ_DEPTH);
      iss_rdy = !(il && m_pend[ird]);
      f1      = m_wr && (m_wa == r1) && (r1 != 0);
      f2      = m_wr && (m_wa == r2) && (r2 != 0);
      chk("ld_ready", ld_ready, rdy);
      chk("issue_ready", issue_ready, iss_rdy);
      chk("busy1", busy1, (r1 != 0) && m_pend[r1]);
      chk("busy2", busy2, (r2 != 0) && m_pend[r2]);
      chk("fwd_valid1", fwd_valid1, f1);
      chk("fwd_valid2", fwd_valid2, f2);
      if (f1) chk("fwd_data1", fwd_data1, m_wd);
      if (f2) chk("fwd_data2", fwd_data2, m_wd);

      acc = lv && rdy;
      sel = 1'b0; sload = 1'b0; srd = '0; sdat = '0;
      if (av) begin
         sel = 1'b1; srd = ard; sdat = adat;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         sel = 1'b1; sload = 1'b1; srd = e.rd; sdat = e.data;
      end else if (acc) begin
         sel = 1'b1; sload = 1'b1; srd = lrd; sdat = ldat; acc = 1'b0;
      end
      if (acc) begin
         e.rd = lrd; e.data = ldat;
         mq.push_back(e);
      end

      @(posedge clk);
      m_wr = sel && (srd != 0);
      if (sel) begin m_wa = srd; m_wd = sdat; end
      if (sel && sload) m_pend[srd] = 1'b0;
      if (iv && il && iss_rdy && ird != 0) m_pend[ird] = 1'b1;

      @(negedge clk);
      chk("rfwrite", rfwrite, m_wr);
      chk("waddr", waddr, m_wa);
      chk("wdata", wdata, m_wd);
   endtask

   task automatic idle(input logic [4:0] r1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      alu_valid = 0; ld_valid = 0; issue_valid = 0;
      issue_is_load = 1'b1; issue_rd = 5'd9; raddr1 = 5'd9; raddr2 = 5'd10;
      #1;
      mq.delete();
      m_pend = '0; m_wr = 1'b0; m_wa = '0; m_wd = '0;
      chk("rst_rfwrite", rfwrite, 1'b0);
      chk("rst_waddr", waddr, 5'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_ld_ready", ld_ready, 1'b1);
      chk("rst_issue_ready", issue_ready, 1'b1);
      chk("rst_busy1", busy1, 1'b0);
      chk("rst_fwd_valid1", fwd_valid1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // ALU only, then forward to a dependent reader
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(5);

      // Collision with a pending load to rd 7
      step(0, 0, 0, 0, 0, 0, 1, 1, 7, 7, 0);
      step(1, 3, 32'hA0A0_0003, 1, 7, 32'h7777_0007, 0, 0, 0, 7, 3);
      idle(7);
      idle(7);

      // Fill the queue behind continuous ALU traffic, then drain
      for (int i = 0; i < 5; i++)
         step(1, 5'(16 + i), 32'h1000 + i, 1, 5'(10 + i), 32'h2000 + i, 0, 0, 0, 5'(10 + i), 0);
      for (int i = 0; i < 6; i++) idle(5'(10 + i));

      // Load-use on rd 9
      step(0, 0, 0, 0, 0, 0, 1, 1, 9, 9, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1, 9, 9, 0);
      step(0, 0, 0, 1, 9, 32'h0909_0909, 1, 1, 9, 9, 0);
      idle(9);

      // x0 handling
      step(1, 0, 32'h1234_5678, 0, 0, 0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 32'hCAFE_0000, 0, 0, 0, 0, 0);
      idle(0);

      // Reset with three loads queued behind ALU traffic
      for (int i = 0; i < 3; i++)
         step(1, 5'(20 + i), 32'h3000 + i, 1, 5'(24 + i), 32'h4000 + i, 1, 1, 5'(24 + i), 5'(24 + i), 0);
      do_reset();
      for (int i = 0; i < 4; i++) idle(5'(24 + i));

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 5, 5'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 9) < 5, 5'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)),
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/rf_writeback_ctrl.md
# rf_writeback_ctrl

Write-side controller for the 32x32 register file: accepts results from the single-cycle ALU path and the variable-latency load path and arbitrates between them. Drives the file's single write port (`rfwrite`, `waddr`, `wdata`) through a registered output stage. Tracks outstanding loads in a pending-register scoreboard so decode can stall on load-use hazards. Forwards the in-flight write to the read ports, because register file reads are combinational and writes land on the clock edge.

## Interface
- `LQ_DEPTH`, 4: load-result queue entries (power of two, ≥2).
- `XLEN`, 32: data width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decode issuing an instruction this cycle.
- `issue_is_load`  in  1  issued instruction is a load.
- `issue_rd`  in  5  destination of issued instruction.
- `issue_ready`  out  1  low when `issue_is_load` and `pending[issue_rd]`; decode must hold.
- `alu_valid`  in  1  ALU result present; always accepted.
- `alu_rd`  in  5  ALU destination.
- `alu_data`  in  XLEN  ALU result.
- `ld_valid`  in  1  load result present.
- `ld_ready`  out  1  load result accepted when `ld_valid && ld_ready`.
- `ld_rd`  in  5  load destination.
- `ld_data`  in  XLEN  load result.
- `raddr1`, `raddr2`  in  5  decode read addresses (same as register file).
- `busy1`, `busy2`  out  1  `pending[raddrN]`, forced 0 for x0.
- `fwd_valid1`, `fwd_valid2`  out  1  `rfwrite && waddr==raddrN && raddrN!=0`.
- `fwd_data1`, `fwd_data2`  out  XLEN  `wdata` (valid only with `fwd_validN`).
- `rfwrite`  out  1  register-file write enable (registered).
- `waddr`  out  5  write address (registered).
- `wdata`  out  XLEN  write data (registered).

## Operation
- Selection, one candidate per cycle, priority order:
  1. `alu_valid`.
  2. Load queue head, if the queue is non-empty.
  3. Accepted `ld_valid` directly, if the queue is empty (bypass, no push).
- Accepted loads that are not selected are pushed into the queue.
- Output stage loads the selected candidate:
  - `rfwrite <= 1` only if the candidate exists and its rd != 0; otherwise `rfwrite <= 0`.
  - `waddr` and `wdata` update only when a candidate is selected.
- A selected candidate with rd==0 consumes the slot and is discarded.
- `ld_ready = !full`. A load is not accepted in the same cycle that the queue pops while full; no pop-through.
- Scoreboard `pending[31:0]`:
  - Set: on `issue_valid && issue_is_load && issue_ready && issue_rd!=0`.
  - Clear: on the edge where a load-sourced candidate with that rd is loaded into the output stage.
  - ALU writes never touch `pending`; WAW ordering against a pending load is decode's responsibility.
  - Simultaneous set and clear of the same bit cannot occur, because `issue_ready` is low while the bit is set.
  - Set and clear of different bits in one cycle both take effect.
- Reset (asserted at any time, including mid-operation):
  - Queue emptied and contents discarded.
  - `pending` = 0.
  - `rfwrite`, `waddr`, `wdata` = 0.
  - Combinational outputs derive from this state: `ld_ready=1`, `issue_ready=1`, busy=0, fwd_valid=0.

## Timing
- ALU result at cycle N: `rfwrite` high in N+1; register file updated at end of N+1. Latency 1.
- Load with empty queue and no ALU: same latency, 1.
- Load blocked by ALU: latency 1 + cycles spent in the queue. Continuous ALU traffic can starve the queue; starvation is accepted by design.
- `busy`, `fwd`, `issue_ready`, `ld_ready`: combinational from registered state and current inputs, zero-cycle.
- A dependent reader in cycle N+1 sees `fwd_valid` for the register being written; from N+2 onward the register file holds the value.
- Queue pointers: `$clog2(LQ_DEPTH)+1` bits; wrap-around modulo `LQ_DEPTH`. Full when MSBs differ and low bits match.

## Structure
- Package `rf_pkg`:
  - `XLEN`, `REG_AW=5`.
  - `typedef struct packed {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;} wb_req_t`.
  - `typedef enum logic {SRC_ALU, SRC_LOAD} wb_src_t`.
- Sub-module `wb_fifo`: synchronous FIFO of `wb_req_t`, parameter `DEPTH`, with push/pop/full/empty and async active-low reset.
- Top-level holds the arbitration, the output stage, the scoreboard and the forwarding compare.

## Test plan
- Reset mid-queue: 3 loads queued behind ALU traffic, then `rst_n` pulsed → `rfwrite=0`, `ld_ready=1`, `pending=0`; no queued write appears after release.
- ALU only: `alu_rd=5`, `alu_data=0xDEADBEEF` at cycle N → `rfwrite=1`, `waddr=5`, `wdata=0xDEADBEEF` at N+1; `raddr1=5` at N+1 gives `fwd_valid1=1`.
- Collision: ALU rd=3 and load rd=7 in the same cycle → rd 3 written at N+1, rd 7 at N+2. `pending[7]` clears at the N+1 edge.
- Queue full: 4 loads accepted while ALU is held valid → `ld_ready=0`. Drop `alu_valid` → entries written in FIFO order, one per cycle, and `ld_ready` returns after the first pop.
- Load-use: issue load rd=9 → `busy1=1` for `raddr1=9` until the write is selected. A second load to rd 9 sees `issue_ready=0` in that window.
- x0 handling: ALU rd=0 → `rfwrite` stays 0. Load issued to rd 0 → no pending bit set, `busy` never asserts, and its result is discarded when selected.
